// File: rtl/stream_demux_1to4_if.sv
// rtl/stream_demux_1to4_if.sv - producer-side stream and four consumer channels of the 1-to-4 demux
interface stream_demux_1to4_if #(
  parameter int DATA_W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_sel;
  logic                in_last;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [4*DATA_W-1:0] out_data;
  logic [3:0]          out_last;

  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_demux_1to4.sv
// rtl/stream_demux_1to4.sv - 1-to-4 stream demux, packet-locked select, one-entry buffer per channel
// Optional per-channel saturating hand-off counters on cnt_flat when STREAM_DEMUX_CNT_EN is defined.
module stream_demux_1to4 #(
  parameter int DATA_W = 8
`ifdef STREAM_DEMUX_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_demux_1to4_if.slave   bus,
  output logic                 busy
`ifdef STREAM_DEMUX_CNT_EN
  , output logic [4*CNT_W-1:0] cnt_flat
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             sel_q;
  logic [1:0]             dest;
  logic [3:0]             buf_free;
  logic                   accept;
  logic                   in_ready_c;
  logic [3:0]             valid_q;
  logic [3:0]             last_q;
  logic [3:0][DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Destination follows in_sel only between packets; mid-packet it is the locked copy.
  always_comb begin
    dest       = (state == BURST) ? sel_q : bus.in_sel;
    buf_free   = ~valid_q | bus.out_ready;
    in_ready_c = rst_n & buf_free[dest];
    accept     = bus.in_valid & in_ready_c;
    state_nxt  = state;
    if (accept) begin
      state_nxt = bus.in_last ? IDLE : BURST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 2'd0;
    end else if (accept && (state == IDLE) && !bus.in_last) begin
      sel_q <= bus.in_sel;
    end
  end

  // A load wins over a drain, so one channel can sustain a beat every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      last_q  <= 4'b0000;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (dest == 2'(i))) begin
          valid_q[i] <= 1'b1;
          last_q[i]  <= bus.in_last;
          data_q[i]  <= bus.in_data;
        end else if (valid_q[i] && bus.out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [3:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (valid_q[i] && bus.out_ready[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign cnt_flat = cnt_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.out_data  = data_q;
  assign busy          = (state == BURST);

endmodule

// File: doc/stream_demux_1to4.md
Name: stream_demux_1to4

Overview:
- 1-to-4 stream demultiplexer: routes one valid/ready input stream to one of four output channels, chosen by a 2-bit select.
- It is the distribution counterpart of the 4:1 selector path. It feeds four downstream consumers from a single producer.
- The select is locked per packet: sampled on the first beat and held until the beat marked last.
- Each output channel has a one-entry registered buffer, giving 1-cycle latency and full throughput.

Parameters:
- DATA_W, 8, width of data payload per beat
- CNT_W, 16, width of per-channel beat counters (used only with the optional feature)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  DATA_W  input payload
- in_sel  in  2  destination channel; sampled on the first beat of a packet only
- in_last  in  1  marks final beat of packet
- out_valid  out  4  per-channel valid; bit i = channel i
- out_ready  in  4  per-channel ready
- out_data  out  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- out_last  out  4  per-channel last flag
- busy  out  1  high while in BURST state
- cnt_flat  out  4*CNT_W  per-channel beat counters (present only with STREAM_DEMUX_CNT_EN)

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - out_valid = 4'b0000, out_last = 0, out_data = 0, busy = 0, locked select = 0, all counters = 0.
  - in_ready = 0 while rst_n is low.
- FSM states:
  - IDLE: no packet in progress. The effective destination is in_sel.
  - BURST: packet in progress. The effective destination is the locked select register.
- Transitions:
  - IDLE -> BURST on an accepted beat with in_last = 0; lock in_sel at that edge.
  - IDLE -> IDLE on an accepted beat with in_last = 1 (single-beat packet).
  - BURST -> IDLE on an accepted beat with in_last = 1.
  - Otherwise hold the current state.
- Channel buffer i is free when out_valid[i] = 0 or out_ready[i] = 1.
- in_ready = rst_n & (destination buffer free). It is combinational from out_ready and state; it never depends on in_valid.
- On an accepted beat, the destination buffer loads in_data and in_last, and sets out_valid[i] = 1 on the next edge. Latency is exactly 1 cycle.
- If buffer i drains (out_valid & out_ready) with no new load, clear out_valid[i].
- Drain and load on the same cycle: the new beat overwrites and out_valid[i] stays 1. This gives back-to-back 1 beat/cycle on one channel.
- Non-destination buffers are unaffected by input activity and drain independently. Multiple channels may be valid at once.
- out_data and out_last hold their value while out_valid[i] & ~out_ready[i] (stable under backpressure).
- Changes to in_sel during BURST are ignored. in_sel is don't-care in BURST.
- busy = (state == BURST).
- Reset mid-packet: all buffered beats are discarded and the FSM returns to IDLE. The next beat is treated as a packet start.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- Defined:
  - Four CNT_W-bit counters, each incremented on every beat handed off on its channel (out_valid[i] & out_ready[i]).
  - Counters saturate at all-ones and do not wrap.
  - They clear on reset only.
  - Exposed on cnt_flat, channel i at [i*CNT_W +: CNT_W].
- Undefined: no counters and no cnt_flat port. Datapath behaviour is identical.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> out_valid = 0000, busy = 0, in_ready = 0. After release with out_ready = 1111 -> in_ready = 1.
- Single-beat packet:
  - Stimulus: in_sel = 2, in_data = 8'hA5, in_last = 1, all out_ready = 1.
  - Response: the next cycle shows out_valid = 0100, out_data[23:16] = A5, out_last[2] = 1, busy stays 0.
- Select lock:
  - Stimulus: 3-beat packet 11,22,33 with in_sel = 1 on beat 1, in_sel changed to 3 on beats 2-3.
  - Response: all three beats appear on channel 1 on consecutive cycles, last flag on 33. busy is high after beat 1 and low after beat 3.
- Backpressure:
  - Stimulus: out_ready[0] = 0, send 2 beats to channel 0.
  - Response: the first beat is buffered; in_ready = 0 and out_data[7:0] is held. Raising out_ready[0] drains beat 1 and accepts beat 2 in the same cycle.
- Independent channels: fill channel 3 with out_ready[3] = 0, then send a beat to channel 0 -> accepted. out_valid = 1001.
- Reset mid-burst:
  - Stimulus: assert rst_n low after beat 2 of a 4-beat packet to channel 1.
  - Response: out_valid = 0000 immediately, busy = 0. A new packet with in_sel = 2 routes to channel 2.
- With STREAM_DEMUX_CNT_EN, 5 beats handed off on channel 2 -> cnt_flat[47:32] = 5, other counters = 0.
